// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32 M-extension multiply/divide unit.
// Latency: none (types, constants and a helper function only).
// Backpressure: none.
package rv32_pkg;

   // funct3 encodings of the M-extension operations
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } muldiv_state_e;

   localparam int          MULDIV_ITER   = 32;
   localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   // funct3[2] separates the divide class from the multiply class
   function automatic logic op_is_div(input muldiv_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/rv32_mod_muldiv_step.sv
// One iteration of the multiply/divide datapath: MSB-first shift-add or restoring shift-subtract.
// Latency: combinational, zero cycles.
// Backpressure: none; the owning FSM decides when the result is captured.
module rv32_mod_muldiv_step (
   input  logic        is_div,
   input  logic [63:0] acc,
   input  logic [31:0] operand,
   input  logic        shift_bit,
   output logic [63:0] acc_next
);

   logic [32:0] rem_sh;
   logic        q_bit;

   // Multiply: acc = 2*acc + (multiplier bit ? multiplicand : 0).
   // Divide: acc[63:32] is the partial remainder, acc[31:0] collects quotient bits.
   always_comb begin
      rem_sh   = {acc[63:32], shift_bit};
      q_bit    = 1'b0;
      acc_next = 64'd0;
      if (is_div) begin
         q_bit = (rem_sh >= {1'b0, operand});
         // When the trial subtraction succeeds the difference is below the divisor,
         // so the low 32 bits of the subtraction are exact.
         if (q_bit) begin
            acc_next = {rem_sh[31:0] - operand, acc[30:0], 1'b1};
         end else begin
            acc_next = {rem_sh[31:0], acc[30:0], 1'b0};
         end
      end else begin
         acc_next = {acc[62:0], 1'b0} + (shift_bit ? {32'd0, operand} : 64'd0);
      end
   end

endmodule

// File: rtl/rv32_mod_muldiv.sv
// Iterative RV32 M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Latency: done 34 cycles after an accepted start (2 cycles for divide-by-zero / signed overflow).
// Backpressure: busy stalls the core while in flight; start is ignored unless idle.
import rv32_pkg::*;

module rv32_mod_muldiv (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  func,
   input  logic [31:0] read0_data,
   input  logic [31:0] read1_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   muldiv_state_e state;
   muldiv_op_e    op;
   logic [5:0]    cnt;
   logic [63:0]   acc;
   logic [63:0]   acc_next;
   logic [31:0]   op_a;
   logic [31:0]   op_b;
   logic          neg_q;
   logic          neg_r;

   muldiv_op_e    op_in;
   logic          a_neg;
   logic          b_neg;
   logic [31:0]   a_mag;
   logic [31:0]   b_mag;
   logic          div_zero;
   logic          div_ovf;
   logic [63:0]   prod_fix;
   logic [31:0]   quo_fix;
   logic [31:0]   rem_fix;
   logic [31:0]   fin_res;

   assign busy = (state != ST_IDLE);

   // Request decode: operand signedness, magnitudes and the special-divide cases
   always_comb begin
      op_in    = muldiv_op_e'(func);
      a_neg    = 1'b0;
      b_neg    = 1'b0;
      case (op_in)
         OP_MULH, OP_DIV, OP_REM: begin
            a_neg = read0_data[31];
            b_neg = read1_data[31];
         end
         OP_MULHSU: a_neg = read0_data[31];
         default: ;
      endcase
      a_mag    = a_neg ? (~read0_data + 32'd1) : read0_data;
      b_mag    = b_neg ? (~read1_data + 32'd1) : read1_data;
      div_zero = op_is_div(op_in) && (read1_data == 32'd0);
      div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                 (read0_data == 32'h8000_0000) && (read1_data == 32'hFFFF_FFFF);
   end

   // Multiply shifts the multiplier MSB-first; divide shifts dividend bits into the remainder
   rv32_mod_muldiv_step u_step (
      .is_div    (op_is_div(op)),
      .acc       (acc),
      .operand   (op_is_div(op) ? op_b : op_a),
      .shift_bit (op_is_div(op) ? op_a[31] : op_b[31]),
      .acc_next  (acc_next)
   );

   // Sign correction and output selection used in FINISH
   always_comb begin
      prod_fix = neg_q ? (~acc + 64'd1) : acc;
      quo_fix  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
      rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
      case (op)
         OP_MUL:                      fin_res = prod_fix[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[63:32];
         OP_DIV, OP_DIVU:             fin_res = quo_fix;
         default:                     fin_res = rem_fix;
      endcase
   end

   // Control FSM with registered done/result; reset drops any in-flight operation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         op     <= OP_MUL;
         cnt    <= 6'd0;
         acc    <= 64'd0;
         op_a   <= 32'd0;
         op_b   <= 32'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         done   <= 1'b0;
         result <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op  <= op_in;
                  cnt <= 6'd0;
                  if (div_zero) begin
                     // Preloaded answer, no sign correction: remainder is rs1 as given
                     acc   <= {read0_data, DIV0_QUOTIENT};
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= ST_FINISH;
                  end else if (div_ovf) begin
                     acc   <= {32'd0, 32'h8000_0000};
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= ST_FINISH;
                  end else begin
                     acc   <= 64'd0;
                     op_a  <= a_mag;
                     op_b  <= b_mag;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc <= acc_next;
               if (op_is_div(op)) begin
                  op_a <= {op_a[30:0], 1'b0};
               end else begin
                  op_b <= {op_b[30:0], 1'b0};
               end
               cnt <= cnt + 6'd1;
               if (cnt == 6'(MULDIV_ITER - 1)) begin
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               result <= fin_res;
               done   <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_mod_muldiv.sv
// Scoreboard bench for rv32_mod_muldiv: directed vectors, queue of expected results.
// Latency: checks done arrives 34 cycles (2 for special divides) after start.
// Backpressure: checks busy span, ignored mid-op starts, back-to-back starts, reset abort.
module tb_rv32_mod_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  func = 3'b000;
   logic [31:0] read0_data = 32'd0;
   logic [31:0] read1_data = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int bcnt;

   logic [31:0] exp_q[$];
   int          cyc_q[$];
   string       name_q[$];

   rv32_mod_muldiv dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .func       (func),
      .read0_data (read0_data),
      .read1_data (read1_data),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done must match the oldest expectation in value and arrival cycle
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: result=%h at cycle %0d, nothing outstanding", result, cyc);
         end else begin
            logic [31:0] e;
            int          ec;
            string       nm;
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (result !== e) begin
               errors++;
               $display("FAIL %s result: got %h expected %h", nm, result, e);
            end
            checks++;
            if (cyc != ec) begin
               errors++;
               $display("FAIL %s latency: done at cycle %0d expected %0d", nm, cyc, ec);
            end
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL %s busy_in_done: got %b expected 0", nm, busy);
            end
         end
      end
   end

   // Called just after a rising edge; start is sampled on the next edge
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat, input string nm);
      start      = 1'b1;
      func       = f;
      read0_data = a;
      read1_data = b;
      exp_q.push_back(e);
      cyc_q.push_back(cyc + lat);
      name_q.push_back(nm);
   endtask

   // Drops start after one edge and waits (bounded) for done, counting busy cycles
   task automatic wait_done(input string nm, output int busy_cnt);
      bit seen;
      seen     = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (busy) busy_cnt++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done within 60 cycles", nm);
      end
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic multiply with busy span
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
      wait_done("mul", bcnt);
      check("mul_busy_cycles", bcnt, 32'd33);

      // Back-to-back stream: each issue lands in the previous done cycle
      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
      wait_done("mulh", bcnt);
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
      wait_done("mulhu", bcnt);
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
      wait_done("mulhsu", bcnt);
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");
      wait_done("div", bcnt);
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");
      wait_done("rem", bcnt);

      // Special divides
      issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0");
      wait_done("divu_by0", bcnt);
      issue(3'b110, 32'd5, 32'd0, 32'd5, 2, "rem_by0");
      wait_done("rem_by0", bcnt);
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
      wait_done("div_ovf", bcnt);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf");
      wait_done("rem_ovf", bcnt);

      // Mid-CALC start and operand changes must be ignored
      issue(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_midstart");
      repeat (5) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      start      = 1'b1;
      func       = 3'b000;
      read0_data = 32'h1234_5678;
      read1_data = 32'd3;
      wait_done("divu_midstart", bcnt);
      issue(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu");
      wait_done("remu", bcnt);

      // Reset at iteration 10 aborts the operation without a done
      start      = 1'b1;
      func       = 3'b000;
      read0_data = 32'd123;
      read1_data = 32'd456;
      repeat (11) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", result, 32'd0);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("abort_idle_busy", {31'd0, busy}, 32'd0);

      issue(3'b000, 32'd3, 32'd4, 32'd12, 34, "mul_after_reset");
      wait_done("mul_after_reset", bcnt);
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
